// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared state encoding and stream header width for the loader
package imem_loader_pkg;
    typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, WRITE, DONE} state_t;
    localparam int HDR_W = 16;
endpackage

// File: rtl/imem_word_assembler.sv
// imem_word_assembler: packs four accepted bytes little-endian into one 32-bit word
module imem_word_assembler (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        shift_en,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_ready
);
    logic [1:0]  cnt;
    logic [31:0] sr;
    // word already includes the byte being accepted, so it is complete on the 4th transfer
    always_comb begin
        word = sr;
        word[{cnt, 3'b000} +: 8] = byte_data;
    end
    assign word_ready = shift_en & (cnt == 2'd3);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            sr  <= '0;
        end else if (clr) begin
            cnt <= '0;
            sr  <= '0;
        end else if (shift_en) begin
            cnt <= cnt + 2'd1;
            sr  <= word;
        end
    end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: loads a length-prefixed byte stream into instruction memory while holding the CPU
module imem_loader import imem_loader_pkg::*; #(
    parameter int          DEPTH     = 32,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        busy,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);
    localparam int KW = $clog2(DEPTH + 1);
    state_t           state, nxt;
    logic [HDR_W-1:0] n, len;
    logic [KW-1:0]    k;
    logic             xfer, accept, word_ready;
    logic [31:0]      word;
    assign xfer   = byte_valid & byte_ready;
    assign accept = start & (state == IDLE || state == DONE);
    assign len    = {byte_data, n[7:0]};
    imem_word_assembler u_asm (
        .clk        (clk),
        .rst        (rst),
        .clr        (accept),
        .shift_en   (xfer && state == DATA),
        .byte_data  (byte_data),
        .word       (word),
        .word_ready (word_ready)
    );
    always_comb begin
        nxt = state;
        case (state)
            IDLE, DONE: nxt = start ? LEN0 : state;
            LEN0:       nxt = xfer ? LEN1 : LEN0;
            LEN1:       nxt = !xfer ? LEN1 : (len == '0 || len > HDR_W'(DEPTH)) ? DONE : DATA;
            DATA:       nxt = word_ready ? WRITE : DATA;
            WRITE:      nxt = (HDR_W'(k) + 16'd1 == n) ? DONE : DATA;
            default:    nxt = IDLE;
        endcase
    end
    assign byte_ready = state inside {LEN0, LEN1, DATA};
    assign busy       = (state inside {LEN0, LEN1, DATA, WRITE}) | accept;
    assign cpu_hold   = busy;
    assign done       = state == DONE;
    assign wr_en      = state == WRITE;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            n       <= '0;
            k       <= '0;
            error   <= 1'b0;
            wr_addr <= BASE_ADDR;
            wr_data <= '0;
        end else begin
            state <= nxt;
            if (accept) begin
                k     <= '0;
                error <= 1'b0;
            end
            if (xfer && state == LEN0)
                n[7:0] <= byte_data;
            if (xfer && state == LEN1) begin
                n[HDR_W-1:8] <= byte_data;
                error        <= len > HDR_W'(DEPTH);
            end
            if (word_ready) begin
                wr_addr <= BASE_ADDR + (32'(k) << 2);
                wr_data <= word;
            end
            if (state == WRITE)
                k <= k + 1'b1;
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed streams checked against a queue-based write model
module tb_imem_loader;
    localparam int          DEPTH = 32;
    localparam logic [31:0] BASE  = 32'h0;
    logic        clk = 0, rst = 1, start = 0, byte_valid = 0;
    logic [7:0]  byte_data = 0;
    logic        byte_ready, wr_en, busy, cpu_hold, done, error;
    logic [31:0] wr_addr, wr_data;
    int          cmp = 0, mis = 0, busy_cyc = 0, hold_cyc = 0;
    logic [63:0] exp_q[$];
    logic [31:0] act_addr[$], act_data[$];
    logic [31:0] last_addr = BASE, last_data = 0;
    logic [7:0]  s[$];

    imem_loader dut (
        .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(byte_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .cpu_hold(cpu_hold), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp++;
        if (act !== exp) begin
            mis++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Expected writes follow directly from the stream: N words, little-endian, consecutive addresses
    task automatic model(input logic [7:0] b[$]);
        int n = {b[1], b[0]};
        if (n == 0 || n > DEPTH) return;
        for (int w = 0; w < n; w++)
            exp_q.push_back({BASE + 32'(4 * w), b[2+4*w+3], b[2+4*w+2], b[2+4*w+1], b[2+4*w]});
    endtask

    always @(negedge clk) if (!rst) begin
        if (busy) busy_cyc++;
        if (cpu_hold) hold_cyc++;
        if (wr_en) begin
            chk("ready_in_write", byte_ready, 0);
            act_addr.push_back(wr_addr);
            act_data.push_back(wr_data);
            if (exp_q.size() == 0) chk("unexpected_write", wr_en, 0);
            else begin
                {last_addr, last_data} = exp_q.pop_front();
                chk("wr_addr", wr_addr, last_addr);
                chk("wr_data", wr_data, last_data);
            end
        end else begin
            chk("hold_addr", wr_addr, last_addr);
            chk("hold_data", wr_data, last_data);
        end
    end

    task automatic start_load(input logic [7:0] b0);
        busy_cyc = 0; hold_cyc = 0;
        act_addr.delete(); act_data.delete();
        @(posedge clk); #1;
        start = 1; byte_valid = 1; byte_data = b0;
        @(posedge clk); #1;
        start = 0;
        chk("done_clr", done, 0);
        chk("error_clr", error, 0);
    endtask

    task automatic send_byte(input logic [7:0] v, input int gap, input bit pulse);
        int t = 0;
        byte_valid = 0;
        repeat (gap) begin @(posedge clk); #1; end
        byte_valid = 1; byte_data = v; start = pulse;
        do begin @(negedge clk); t++; end while (!byte_ready && t < 100);
        chk("byte_ready", byte_ready, 1);
        @(posedge clk); #1;
        byte_valid = 0; start = 0;
    endtask

    task automatic wait_done();
        int t = 0;
        while (!done && t < 200) begin @(negedge clk); t++; end
        chk("done", done, 1);
    endtask

    task automatic run(input logic [7:0] b[$], input int gap, input int pulse_at);
        model(b);
        start_load(b[0]);
        foreach (b[i]) send_byte(b[i], i == 0 ? 0 : gap, i == pulse_at);
        wait_done();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"}, byte_ready, 0);
        chk({tag, "_wr_en"}, wr_en, 0);
        chk({tag, "_addr"}, wr_addr, BASE);
        chk({tag, "_data"}, wr_data, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_hold"}, cpu_hold, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_error"}, error, 0);
    endtask

    task automatic chk_two_words(input string tag);
        chk({tag, "_nwr"}, act_addr.size(), 2);
        chk({tag, "_a0"}, act_addr[0], 32'h0);
        chk({tag, "_d0"}, act_data[0], 32'h8CDEFAB7);
        chk({tag, "_a1"}, act_addr[1], 32'h4);
        chk({tag, "_d1"}, act_data[1], 32'h0064A423);
        chk({tag, "_err"}, error, 0);
    endtask

    initial begin
        #1 chk_reset_vals("rst0");
        repeat (2) @(posedge clk);
        #1 rst = 0;

        s = '{8'h02, 8'h00, 8'hB7, 8'hFA, 8'hDE, 8'h8C, 8'h23, 8'hA4, 8'h64, 8'h00};
        run(s, 0, -1);
        chk_two_words("two");

        s = '{8'h00, 8'h00};
        run(s, 0, -1);
        chk("zero_err", error, 0);
        chk("zero_nwr", act_addr.size(), 0);
        chk("zero_busy", busy_cyc, 3);
        chk("zero_hold", hold_cyc, 3);

        s = '{8'h21, 8'h00};
        run(s, 0, -1);
        chk("ovf_err", error, 1);
        chk("ovf_nwr", act_addr.size(), 0);
        byte_valid = 1; byte_data = 8'h55;
        repeat (3) begin @(negedge clk); chk("ovf_ready", byte_ready, 0); end
        byte_valid = 0;

        s = '{8'h01, 8'h00, 8'h33, 8'hE2, 8'h62, 8'h00};
        run(s, 1, -1);
        chk("gap_nwr", act_addr.size(), 1);
        chk("gap_a0", act_addr[0], 32'h0);
        chk("gap_d0", act_data[0], 32'h0062E233);
        chk("gap_err", error, 0);

        s = '{8'h02, 8'h00, 8'hB7, 8'hFA, 8'hDE, 8'h8C, 8'h23, 8'hA4, 8'h64, 8'h00};
        run(s, 0, 4);
        chk_two_words("pulse");

        model(s);
        start_load(s[0]);
        for (int i = 0; i < 5; i++) send_byte(s[i], 0, 0);
        #2 rst = 1;
        #1 chk_reset_vals("rst_mid");
        chk("rst_nwr", act_addr.size(), 0);
        exp_q.delete(); last_addr = BASE; last_data = 0;
        @(posedge clk); #1 rst = 0;
        repeat (3) @(negedge clk);
        run(s, 0, -1);
        chk_two_words("reload");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
        $finish;
    end
endmodule
